// File: rtl/rr_mux_arb_pkg.sv
// Shared types for the round-robin mux arbiter: state encoding, requester count
// and the 2-bit select type that drives the shared 4:1 data mux.
package rr_mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] sel_onehot(input sel_t s);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one search: lowest offset from ptr (mod 4) with req set wins.
// Purely combinational, zero latency, no flow control.
module rr_pick
  import rr_mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             found,
  output sel_t             idx
);

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    sel_t cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with tenure limit driving a shared 4:1 data mux; grant is
// registered one cycle after req, dout combinational. Optional RR_MUX_ARBITER_LOCK_EN adds lock.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int N_REQ    = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RR_MUX_ARBITER_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             dout
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_e           state_q, state_d;
  sel_t             ptr_q, ptr_d;
  sel_t             sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic             hold_expired;
  logic             release_w;
  sel_t             pick_ptr;
  logic             pick_found;
  sel_t             pick_idx;

`ifdef RR_MUX_ARBITER_LOCK_EN
  assign hold_expired = (cnt_q == HOLD_LIM) && !lock;
`else
  assign hold_expired = (cnt_q == HOLD_LIM);
`endif

  assign release_w = (state_q == GRANT) && (!req[sel_q] || hold_expired);

  // On release the search restarts just past the outgoing owner, in the same cycle.
  assign pick_ptr = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = sel_onehot(pick_idx);
          busy_d  = 1'b1;
          cnt_d   = 4'd1;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end

      GRANT: begin
        if (release_w) begin
          ptr_d = sel_q + 2'd1;
          if (pick_found) begin
            sel_d = pick_idx;
            gnt_d = sel_onehot(pick_idx);
            cnt_d = 4'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
          end
        end else if (cnt_q != HOLD_LIM) begin
          // Saturates under lock so the count never wraps past the limit.
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign dout = busy_q ? din[sel_q] : 1'b0;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles per tenure (legal range 1..15).
REQ-002 SHALL have parameter N_REQ, default 4, meaning the number of requesters; it is fixed at 4 to match the 2-bit select.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 4 bits: per-requester request, held high while access is wanted.
REQ-006 SHALL have port din, input, 4 bits: per-requester data bit, din[i] belonging to requester i.
REQ-007 SHALL have port gnt, output, 4 bits: registered one-hot grant, or all-zero when idle.
REQ-008 SHALL have port sel, output, 2 bits: registered index of the granted requester, for driving the shared 4:1 mux.
REQ-009 SHALL have port busy, output, 1 bit: registered; high while any grant is active.
REQ-010 SHALL have port dout, output, 1 bit: combinational din[sel] when busy is high, 0 otherwise.

Function
REQ-011 SHALL implement states IDLE and GRANT, plus a 2-bit round-robin pointer ptr and a hold counter cnt.
REQ-012 SHALL, in IDLE with req==0, stay in IDLE with gnt=0, busy=0 and sel holding its last value.
REQ-013 SHALL, in IDLE with req!=0, choose the first asserted index scanning ptr, ptr+1, ... mod 4.
REQ-014 SHALL, on that choice, assert gnt, sel and busy on the next edge (latency 1 cycle from req), enter GRANT and set cnt=1.
REQ-015 SHALL, in GRANT, release the grant when req[sel]==0 or cnt==MAX_HOLD, and otherwise increment cnt and hold the grant.
REQ-016 SHALL, on release, set ptr=(sel+1) mod 4 and re-arbitrate in the same cycle using the new ptr.
REQ-017 SHALL, if that re-arbitration finds a request, switch gnt/sel directly on the next edge with no idle gap and set cnt=1.
REQ-018 SHALL, if that re-arbitration finds no request, go to IDLE with gnt=0 and busy=0.
REQ-019 SHALL re-grant a requester whose tenure just expired when it is the only one still requesting (wrap-around case).
REQ-020 SHALL never assert more than one gnt bit, and SHALL keep gnt==(busy ? 1<<sel : 0) at all times.
REQ-021 SHALL ignore req changes on non-granted inputs during a tenure, apart from their effect at re-arbitration.

Reset
REQ-022 SHALL, when rst is high at an edge, set state=IDLE, gnt=0, sel=0, busy=0, ptr=0 and cnt=0, regardless of state.
REQ-023 SHALL, with reset asserted mid-tenure, drop the grant on that edge with no completion of the tenure.
REQ-024 SHALL, after reset, treat requester 0 as highest priority for the first arbitration.

Configuration
REQ-025 SHALL, when macro RR_MUX_ARBITER_LOCK_EN is defined, add input port lock (1 bit).
REQ-026 SHALL, with lock high in GRANT, suppress the cnt==MAX_HOLD release so that only req[sel]==0 releases; cnt saturates at MAX_HOLD.
REQ-027 SHALL, when the macro is undefined, have no lock port and always enforce MAX_HOLD.

Structure
REQ-028 SHALL place the state enum (IDLE, GRANT), the N_REQ constant and the 2-bit sel typedef in shared package rr_mux_arb_pkg.
REQ-029 SHALL implement the rotating first-one search as combinational sub-module rr_pick (inputs req and ptr; outputs found and idx).

Verification
REQ-030 SHALL verify: after reset, req=4'b0100 -> one cycle later gnt=4'b0100, sel=2, busy=1, dout=din[2].
REQ-031 SHALL verify: req=4'b1111 held constantly with MAX_HOLD=4 -> grants run 0,1,2,3,0 for 4 cycles each, with no gap between tenures.
REQ-032 SHALL verify: granted to 1 with req=4'b0010, req[1] drops at cnt=2 -> next edge busy=0, gnt=0, ptr=2.
REQ-033 SHALL verify: only req[3] held high for 10 cycles -> gnt=4'b1000 continuously (re-granted to 3 on expiry via wrap-around).
REQ-034 SHALL verify: rst pulsed for 1 cycle mid-tenure on sel=2 -> next edge gnt=0, sel=0; with req=4'b1100 afterwards, the grant goes to 2.
REQ-035 SHALL verify, with RR_MUX_ARBITER_LOCK_EN defined: lock=1 and req=4'b0011 with 0 granted -> 0 keeps the grant beyond 4 cycles until req[0] drops, then 1 is granted.
